// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage, WIDTH-bit register pipeline with a valid bit
// per stage and valid/ready flow control. Stalled stages hold their data,
// and bubbles collapse even while the output is stalled. Provides a
// synchronous flush and a registered occupancy count.
//
// Build option: define PIPE_NEGEDGE_CLK_EN to make every register capture on
// the falling edge of clk. The default build captures on the rising edge.
// The asynchronous active-low reset is the same in both builds.
//
// Ports:
//   clk        clock (active edge selected by PIPE_NEGEDGE_CLK_EN)
//   rst_n      asynchronous active-low reset; clears all stages
//   in_valid   upstream data valid
//   in_data    upstream data
//   in_ready   chain accepts in_data this cycle (combinational)
//   out_valid  last stage holds valid data
//   out_data   data of the last stage
//   out_ready  downstream accepts out_data this cycle
//   flush      synchronous clear of all valid bits
//   occupancy  number of valid stages, 0..DEPTH
module pipe_reg_chain #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;

  // Ready chain: a stage may load when it is empty or everything ahead of
  // it can move. Built from the output end with a running accumulator.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc    = ~v_q[i] | acc;
      rdy[i] = acc;
    end
  end

  // Stage advance; flush drops every valid bit and leaves data as is.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        data_d[0] = in_data;
        v_d[0]    = in_valid;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          data_d[i] = data_q[i-1];
          v_d[i]    = v_q[i-1];
        end
      end
    end
  end

  // Occupancy is the popcount of the post-edge valid bits.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + CNT_W'(v_d[i]);
    end
  end

  // Stage and occupancy registers.
`ifdef PIPE_NEGEDGE_CLK_EN
  always_ff @(negedge clk or negedge rst_n) begin
`else
  always_ff @(posedge clk or negedge rst_n) begin
`endif
    if (!rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      occ_q  <= occ_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Testbench for pipe_reg_chain (WIDTH=8, DEPTH=4). Directed scenarios plus
// random traffic; a word-position queue model predicts in_ready, out_valid,
// occupancy and the order/content of delivered words.
module tb_pipe_reg_chain;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;
  logic [2:0]   occupancy;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words in flight, oldest first, with the stage each one occupies.
  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } word_t;

  word_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, then advances the model by one
  // rising edge using the inputs that edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      logic exp_ir;
      logic exp_ov;
      int   lim;
      exp_ir = !flush && (sb.size() < int'(D) || out_ready);
      exp_ov = sb.size() > 0 && sb[0].pos == int'(D) - 1;
      chk("in_ready", int'(in_ready), int'(exp_ir));
      chk("out_valid", int'(out_valid), int'(exp_ov));
      chk("occupancy", int'(occupancy), sb.size());
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("out_data", int'(out_data), int'(sb[0].data));
          sb.pop_front();
        end
      end
      if (flush) begin
        sb.delete();
      end else begin
        // Each word moves one stage unless its predecessor's new slot blocks it.
        lim = int'(D) - 1;
        for (int k = 0; k < sb.size(); k++) begin
          int np;
          np = sb[k].pos + 1;
          if (np > lim) np = lim;
          sb[k].pos = np;
          lim = np - 1;
        end
        if (in_valid && exp_ir) sb.push_back('{in_data, 0});
      end
    end
  end

  // Drive inputs just after the rising edge; they apply to the next one.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (guard < 30) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      if (occupancy == 3'd0 && !out_valid) break;
      guard++;
    end
    chk("drain_done", int'(guard < 30), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_k;
    int idx;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-stream: load three words, then pulse reset between edges.
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'hE0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_occupancy", int'(occupancy), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    first_k = -1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k > 0 && first_k < 0 && out_valid) begin
        first_k = k;
        chk("post_rst_first_data", int'(out_data), 'h11);
      end
      in_valid  = (k == 0);
      in_data   = 8'h11;
      out_ready = 1'b1;
    end
    chk("post_rst_latency", first_k, int'(D));
    drain();

    // Latency and full-rate streaming.
    first_k = -1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (k > 0 && first_k < 0 && out_valid) begin
        first_k = k;
        chk("stream_first_data", int'(out_data), 'h01);
      end
      in_valid  = (k < 8);
      in_data   = W'(k + 1);
      out_ready = 1'b1;
    end
    chk("stream_latency", first_k, int'(D));
    drain();

    // Fill under backpressure, then release.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(idx < 6, W'(8'hA0 + idx), 1'b0, 1'b0);
      #1;
      if (in_valid && in_ready) idx++;
    end
    chk("full_accepted", idx, 4);
    chk("full_occupancy", int'(occupancy), 4);
    chk("full_in_ready", int'(in_ready), 0);
    for (int c = 0; c < 20 && idx < 6; c++) begin
      step(1'b1, W'(8'hA0 + idx), 1'b1, 1'b0);
      #1;
      if (in_ready) idx++;
    end
    chk("full_all_sent", idx, 6);
    drain();

    // Bubble collapse with the output stalled.
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h30, 1'b0, 1'b0);
    #1;
    chk("bubble_occupancy", int'(occupancy), 2);
    chk("bubble_in_ready", int'(in_ready), 1);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    #1;
    chk("bubble_occ_after", int'(occupancy), 3);
    chk("flush_in_ready", int'(in_ready), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("flush_occupancy", int'(occupancy), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    for (int c = 0; c < 8; c++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full pipe with simultaneous input and output every cycle.
    for (int c = 0; c < 4; c++) step(1'b1, W'(8'hC0 + c), 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, W'(8'hC4 + j), 1'b1, 1'b0);
      #1;
      chk("steady_occupancy", int'(occupancy), 4);
      chk("steady_in_ready", int'(in_ready), 1);
    end
    drain();

    // Random traffic with occasional flush.
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 5,
           $urandom_range(0, 31) == 0);
    end
    drain();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
